// File: rtl/alu_muldiv_if.sv
// Handshake bundle between the EX stage and the multi-cycle mul/div unit.
// Operand side: in_valid/in_ready with op, a, b. Result side: out_valid/out_ready
// with result. flush aborts an in-flight operation, and busy reports a non-idle unit.
interface alu_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             busy;

   // Upstream pipeline / consumer side
   modport master (
      output in_valid, op, a, b, flush, out_ready,
      input  in_ready, out_valid, result, busy
   );

   // Execute unit side
   modport slave (
      input  in_valid, op, a, b, flush, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M execute unit. MUL/MULH/MULHSU/MULHU use a shift-add multiplier.
// DIV/DIVU/REM/REMU use a restoring divider. Both work on operand magnitudes, and a
// single sign fix is applied once the iterations finish. Divide-by-zero and signed
// overflow bypass the iterations and go straight to DONE.
module alu_muldiv #(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         rstn,
   alu_muldiv_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [2:0]       op_reg;
   logic             neg_reg;     // final result must be negated in FIX
   logic [WIDTH-1:0] hi_reg;      // product upper half / partial remainder
   logic [WIDTH-1:0] lo_reg;      // multiplier being consumed / dividend becoming quotient
   logic [WIDTH-1:0] md_reg;      // multiplicand or divisor magnitude
   logic [WIDTH-1:0] result_reg;
   logic             out_valid_reg;

   logic             in_ready;

   assign in_ready      = (state_reg == IDLE) && !bus.flush;
   assign bus.in_ready  = in_ready;
   assign bus.busy      = (state_reg != IDLE);
   assign bus.out_valid = out_valid_reg;
   assign bus.result    = result_reg;

   // Operand decode at accept time: signedness, magnitudes, result sign, shortcuts
   logic             a_signed, b_signed, a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic             neg_next;
   logic             div_zero, div_ovf, special;
   logic [WIDTH-1:0] special_val;

   always_comb begin
      a_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                 (bus.op == OP_DIV)  || (bus.op == OP_REM);
      b_signed = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
      a_neg    = a_signed && bus.a[WIDTH-1];
      b_neg    = b_signed && bus.b[WIDTH-1];
      a_abs    = a_neg ? -bus.a : bus.a;
      b_abs    = b_neg ? -bus.b : bus.b;
      // The remainder follows the dividend's sign; everything else is the sign product
      neg_next = (bus.op == OP_REM) ? a_neg : (a_neg ^ b_neg);
      div_zero = bus.op[2] && (bus.b == '0);
      div_ovf  = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                 (bus.a == MOST_NEG) && (bus.b == ALL_ONES);
      special  = div_zero || div_ovf;
      // op[1] separates REM/REMU (6,7) from DIV/DIVU (4,5)
      if (div_zero) begin
         special_val = bus.op[1] ? bus.a : ALL_ONES;
      end else begin
         special_val = bus.op[1] ? '0 : bus.a;
      end
   end

   // One shift-add multiply step and one restoring divide step on the shared registers
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_sub;
   logic             div_ge;

   always_comb begin
      mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, md_reg} : {(WIDTH+1){1'b0}});
      div_shift = {hi_reg, lo_reg[WIDTH-1]};
      // The partial remainder stays below the divisor, so the shifted value is below
      // twice the divisor and the kept difference always fits in WIDTH bits
      div_ge    = div_shift[WIDTH] || (div_shift[WIDTH-1:0] >= md_reg);
      div_sub   = div_shift[WIDTH-1:0] - md_reg;
   end

   // Sign correction and result selection for the FIX state
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix, fix_val;

   always_comb begin
      prod_fix = neg_reg ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
      quot_fix = neg_reg ? -lo_reg : lo_reg;
      rem_fix  = neg_reg ? -hi_reg : hi_reg;
      case (op_reg)
         OP_MUL:                      fix_val = prod_fix[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:             fix_val = quot_fix;
         default:                     fix_val = rem_fix;
      endcase
   end

   // Control FSM and datapath registers; flush overrides every non-idle state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         op_reg        <= '0;
         neg_reg       <= 1'b0;
         hi_reg        <= '0;
         lo_reg        <= '0;
         md_reg        <= '0;
         result_reg    <= '0;
         out_valid_reg <= 1'b0;
      end else if (bus.flush && (state_reg != IDLE)) begin
         state_reg     <= IDLE;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.in_valid && in_ready) begin
                  op_reg  <= bus.op;
                  neg_reg <= neg_next;
                  cnt_reg <= CNT_W'(WIDTH);
                  hi_reg  <= '0;
                  if (special) begin
                     result_reg    <= special_val;
                     out_valid_reg <= 1'b1;
                     state_reg     <= DONE;
                  end else if (bus.op[2]) begin
                     lo_reg    <= a_abs;
                     md_reg    <= b_abs;
                     state_reg <= DIV;
                  end else begin
                     lo_reg    <= b_abs;
                     md_reg    <= a_abs;
                     state_reg <= MUL;
                  end
               end
            end
            MUL: begin
               hi_reg  <= mul_sum[WIDTH:1];
               lo_reg  <= {mul_sum[0], lo_reg[WIDTH-1:1]};
               cnt_reg <= cnt_reg - CNT_W'(1);
               if (cnt_reg == CNT_W'(1)) begin
                  state_reg <= FIX;
               end
            end
            DIV: begin
               hi_reg  <= div_ge ? div_sub : div_shift[WIDTH-1:0];
               lo_reg  <= {lo_reg[WIDTH-2:0], div_ge};
               cnt_reg <= cnt_reg - CNT_W'(1);
               if (cnt_reg == CNT_W'(1)) begin
                  state_reg <= FIX;
               end
            end
            FIX: begin
               result_reg    <= fix_val;
               out_valid_reg <= 1'b1;
               state_reg     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32). It applies a vector table of
// constant expectations, a short random batch against a 64-bit reference model,
// and hand-written backpressure, flush and asynchronous-reset sequences.
// Results are matched against a scoreboard queue as they leave the unit.
module tb_alu_muldiv;
   localparam int W = 32;

   logic clk;
   logic rstn;

   alu_muldiv_if #(.WIDTH(W)) bus ();

   alu_muldiv #(.WIDTH(W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] exp;
   } sb_t;

   sb_t sb[$];
   int  checks = 0;
   int  errors = 0;
   int  txns   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Reference model built on 64-bit native arithmetic
   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
      longint      sx, sy, ux, uy, p;
      logic [63:0] pu;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'd0, x});
      uy = longint'({32'd0, y});
      p  = 0;
      case (o)
         3'd0: p = ux * uy;
         3'd1: p = sx * sy;
         3'd2: p = sx * uy;
         3'd3: p = ux * uy;
         3'd4: p = (y == 0) ? -1 : sx / sy;
         3'd5: p = (y == 0) ? -1 : ux / uy;
         3'd6: p = (y == 0) ? sx : sx % sy;
         default: p = (y == 0) ? ux : ux % uy;
      endcase
      pu = p;
      if (o == 3'd1 || o == 3'd2 || o == 3'd3) begin
         return pu[63:32];
      end
      return pu[31:0];
   endfunction

   // Scoreboard: compare each result on the cycle it is handed over
   always @(negedge clk) begin
      if (rstn && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %08h expected no result", bus.result);
         end else begin
            sb_t e;
            e = sb.pop_front();
            txns++;
            $display("txn %0d op=%0d result=%08h expected=%08h", txns, e.op, bus.result, e.exp);
            check("result", bus.result, e.exp);
         end
      end
   end

   // Present one op with out_ready=1, record it on accept, and measure its latency.
   // Entered and left at posedge+1 with the unit idle.
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e, input int lat);
      int edges;
      bit acc;
      bus.op        = o;
      bus.a         = x;
      bus.b         = y;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      acc   = 1'b0;
      edges = 0;
      while (!acc && edges < 50) begin
         @(negedge clk);
         acc = bus.in_ready;
         if (acc) sb.push_back('{o, e});
         @(posedge clk);
         #1;
         edges++;
      end
      bus.in_valid = 1'b0;
      check("accept", 32'(acc), 32'd1);
      if (!acc) return;
      edges = 1;
      while (!bus.out_valid && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check("latency", 32'(edges), 32'(lat));
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[20];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  seen;
      bit  ovs;
      logic [2:0]  ro;
      logic [31:0] ra, rb;

      vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
      vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34};
      vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
      vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34};
      vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
      vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
      vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       34};
      vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        34};
      vecs[8]  = '{3'd5, 32'h1234,     32'd0,        32'hFFFFFFFF, 1};
      vecs[9]  = '{3'd7, 32'h1234,     32'd0,        32'h1234,     1};
      vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
      vecs[12] = '{3'd4, 32'd7,        32'd0,        32'hFFFFFFFF, 1};
      vecs[13] = '{3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1};
      vecs[14] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        34};
      vecs[15] = '{3'd1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 34};
      vecs[16] = '{3'd2, 32'd2,        32'hFFFFFFFF, 32'd1,        34};
      vecs[17] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        34};
      vecs[18] = '{3'd4, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'd4,        34};
      vecs[19] = '{3'd5, 32'hFFFFFFFF, 32'd10,       32'h19999999, 34};

      rstn          = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op        = 3'd0;
      bus.a         = '0;
      bus.b         = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy",      32'(bus.busy),      32'd0);
      check("rst_result",    bus.result,         32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Vector table
      for (int i = 0; i < 20; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      end

      // Random batch against the reference model, with forced corner operands
      for (int i = 0; i < 16; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            2: rb = 32'($urandom_range(1, 20));
            default: ;
         endcase
         ovs = ro[2] && ((rb == 0) ||
               ((ro == 3'd4 || ro == 3'd6) && ra == 32'h80000000 && rb == 32'hFFFFFFFF));
         run_op(ro, ra, rb, model(ro, ra, rb), ovs ? 1 : 34);
      end

      // Backpressure: result held in DONE while out_ready is low
      bus.op        = 3'd0;
      bus.a         = 32'd6;
      bus.b         = 32'd7;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd1);
      sb.push_back('{3'd0, 32'd42});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      seen = 0;
      while (!bus.out_valid && seen < 100) begin
         @(posedge clk);
         #1;
         seen++;
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_out_valid", 32'(bus.out_valid), 32'd1);
         check("bp_result",    bus.result,         32'd42);
         check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", 32'(bus.out_valid), 32'd0);
      check("bp_release_ready", 32'(bus.in_ready),  32'd1);
      bus.op       = 3'd5;
      bus.a        = 32'd200;
      bus.b        = 32'd10;
      bus.in_valid = 1'b1;
      sb.push_back('{3'd5, 32'd20});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("bp_next_accept", 32'(bus.busy), 32'd1);
      seen = 0;
      while (!bus.out_valid && seen < 100) begin
         @(posedge clk);
         #1;
         seen++;
      end
      check("bp_next_latency", 32'(seen + 1), 32'd34);
      @(posedge clk);
      #1;

      // Flush during the 10th multiply iteration
      bus.op       = 3'd0;
      bus.a        = 32'd11;
      bus.b        = 32'd13;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("fl_busy_after_accept", 32'(bus.busy), 32'd1);
      repeat (9) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      check("fl_busy",      32'(bus.busy),      32'd0);
      check("fl_out_valid", 32'(bus.out_valid), 32'd0);
      // Flush with in_valid while idle must not accept
      bus.in_valid = 1'b1;
      #1;
      check("fl_idle_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("fl_idle_no_accept", 32'(bus.busy), 32'd0);
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen++;
      end
      check("fl_never_valid", 32'(seen), 32'd0);
      run_op(3'd5, 32'd9, 32'd3, 32'd3, 34);

      // Asynchronous reset in the middle of a divide
      bus.op       = 3'd4;
      bus.a        = 32'd1000;
      bus.b        = 32'd3;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("ar_busy_before", 32'(bus.busy), 32'd1);
      repeat (5) @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check("ar_busy",      32'(bus.busy),      32'd0);
      check("ar_out_valid", 32'(bus.out_valid), 32'd0);
      check("ar_result",    bus.result,         32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      run_op(3'd0, 32'd3, 32'd5, 32'd15, 34);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
